// File: rtl/sdm_dec.sv
// Decimating accumulator behind sdm_rx: sums groups of 2^RATE signed words pulled
// through the full/toggle-pop handshake and offers each sum through the same handshake.
module sdm_dec #(
  parameter  int unsigned DMSB = 3,
  parameter  int unsigned RATE = 2,
  localparam int unsigned OMSB = DMSB + RATE
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          setn,
  input  logic          in_full,
  input  logic [DMSB:0] in_rdata,
  output logic          in_pop,
  output logic          full,
  input  logic          pop,
  input  logic          clear,
  output logic [OMSB:0] rdata,
  output logic [1:0]    xst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam logic [RATE-1:0] CNT_LAST = '1;

  state_e          state_q;
  logic [OMSB:0]   acc_q;
  logic [OMSB:0]   rdata_q;
  logic [RATE-1:0] cnt_q;
  logic            pop_q;
  logic            full_q;
  logic            in_pop_q;

  logic [OMSB:0]   sample_ext_c;
  logic            pop_edge_c;
  logic            flush_c;

  // Sign-extended sample; N samples of DMSB+1 bits always fit in OMSB+1 bits.
  assign sample_ext_c = {{RATE{in_rdata[DMSB]}}, in_rdata};
  assign pop_edge_c   = pop ^ pop_q;
  assign flush_c      = clear | ~setn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      pop_q    <= 1'b0;
      full_q   <= 1'b0;
      in_pop_q <= 1'b0;
    end else begin
      pop_q <= pop;
      if (flush_c) begin
        // rdata and in_pop are kept so the flush never looks like an upstream pop.
        acc_q   <= '0;
        cnt_q   <= '0;
        full_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        if (pop_edge_c) begin
          full_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (in_full) begin
              acc_q    <= acc_q + sample_ext_c;
              in_pop_q <= ~in_pop_q;
              state_q  <= WAIT;
            end
          end
          WAIT: begin
            // Dropping in_full is the upstream acknowledge of the toggle.
            if (!in_full) begin
              if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                state_q <= EMIT;
              end else begin
                cnt_q   <= cnt_q + RATE'(1);
                state_q <= IDLE;
              end
            end
          end
          EMIT: begin
            // Stall while the previous sum is still unreleased.
            if (!full_q) begin
              rdata_q <= acc_q;
              full_q  <= 1'b1;
              acc_q   <= '0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_pop = in_pop_q;
  assign full   = full_q;
  assign rdata  = rdata_q;
  assign xst    = state_q;

endmodule

// File: tb/tb_sdm_dec.sv
// Self-checking bench for sdm_dec: upstream word model, scoreboard of expected sums.
module tb_sdm_dec;

  localparam int unsigned DMSB = 3;
  localparam int unsigned RATE = 2;
  localparam int unsigned OMSB = DMSB + RATE;

  logic          clk = 1'b0;
  logic          rstn;
  logic          setn;
  logic          in_full;
  logic [DMSB:0] in_rdata;
  logic          in_pop;
  logic          full;
  logic          pop;
  logic          clear;
  logic [OMSB:0] rdata;
  logic [1:0]    xst;

  int chk;
  int err;
  int tog_cnt;
  int drop_t;
  logic pop_seen;
  logic full_prev;
  logic [DMSB:0]        up_q[$];
  logic signed [OMSB:0] exp_q[$];
  logic signed [OMSB:0] exp_v;

  sdm_dec #(.DMSB(DMSB), .RATE(RATE)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .setn     (setn),
    .in_full  (in_full),
    .in_rdata (in_rdata),
    .in_pop   (in_pop),
    .full     (full),
    .pop      (pop),
    .clear    (clear),
    .rdata    (rdata),
    .xst      (xst)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input int v);
    up_q.push_back(4'(v));
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d);
    send_word(a); send_word(b); send_word(c); send_word(d);
    exp_q.push_back(6'(a + b + c + d));
  endtask

  task automatic wait_tog(input int base, input int n, input string tag);
    int k = 0;
    while ((tog_cnt - base) < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk++;
    if ((tog_cnt - base) < n) begin
      err++;
      $display("FAIL %s_tog_timeout got=%0d want=%0d", tag, tog_cnt - base, n);
    end
  endtask

  task automatic wait_full(input string tag);
    int k = 0;
    @(negedge clk);
    while (full !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk++;
    if (full !== 1'b1) begin
      err++;
      $display("FAIL %s_full_timeout got=%b want=1", tag, full);
    end
  endtask

  task automatic do_pop();
    @(negedge clk);
    pop = ~pop;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk++; if (in_pop !== 1'b0) begin err++; $display("FAIL rst_in_pop got=%b want=0", in_pop); end
    chk++; if (full !== 1'b0)   begin err++; $display("FAIL rst_full got=%b want=0", full); end
    chk++; if (rdata !== 6'd0)  begin err++; $display("FAIL rst_rdata got=%0d want=0", rdata); end
    chk++; if (xst !== 2'd0)    begin err++; $display("FAIL rst_xst got=%0d want=0", xst); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk++; if (xst !== 2'd0) begin err++; $display("FAIL rst_idle_xst got=%0d want=0", xst); end
  endtask

  task automatic test_basic();
    int base = tog_cnt;
    send_group(1, 2, 3, 4);
    wait_full("basic");
    chk++;
    if (tog_cnt - base !== 4) begin err++; $display("FAIL basic_tog got=%0d want=4", tog_cnt - base); end
    do_pop();
    @(posedge clk); #1;
    chk++; if (full !== 1'b0) begin err++; $display("FAIL basic_pop_full got=%b want=0", full); end
    chk++; if ($signed(rdata) !== 6'sd10) begin err++; $display("FAIL basic_hold got=%0d want=10", $signed(rdata)); end
  endtask

  task automatic test_range();
    send_group(-8, -8, -8, -8);
    wait_full("range_neg");
    chk++; if (rdata !== 6'b100000) begin err++; $display("FAIL range_neg got=%b want=100000", rdata); end
    do_pop();
    send_group(7, 7, 7, 7);
    wait_full("range_pos");
    chk++; if (rdata !== 6'd28) begin err++; $display("FAIL range_pos got=%0d want=28", rdata); end
    do_pop();
  endtask

  task automatic test_back_to_back();
    int base = tog_cnt;
    logic pop_snap;
    send_group(1, 2, 3, 4);
    send_group(-1, -2, -3, -4);
    send_group(7, -8, 5, -6);
    wait_tog(base, 8, "bp");
    pop_snap = in_pop;
    repeat (12) @(negedge clk);
    chk++; if (tog_cnt - base !== 8) begin err++; $display("FAIL bp_tog got=%0d want=8", tog_cnt - base); end
    chk++; if (in_pop !== pop_snap) begin err++; $display("FAIL bp_in_pop got=%b want=%b", in_pop, pop_snap); end
    chk++; if (xst !== 2'd2) begin err++; $display("FAIL bp_xst got=%0d want=2", xst); end
    chk++; if ($signed(rdata) !== 6'sd10) begin err++; $display("FAIL bp_hold got=%0d want=10", $signed(rdata)); end
    do_pop();
    @(posedge clk); #1;
    chk++; if (full !== 1'b0) begin err++; $display("FAIL bp_release got=%b want=0", full); end
    @(posedge clk); #1;
    chk++; if (full !== 1'b1) begin err++; $display("FAIL bp_second_full got=%b want=1", full); end
    chk++; if ($signed(rdata) !== -6'sd10) begin err++; $display("FAIL bp_second got=%0d want=-10", $signed(rdata)); end
    wait_tog(base, 12, "bp3");
    repeat (12) @(negedge clk);
    chk++; if (xst !== 2'd2) begin err++; $display("FAIL bp3_xst got=%0d want=2", xst); end
    do_pop();
    wait_full("bp3");
    do_pop();
    @(posedge clk); #1;
    chk++; if (full !== 1'b0) begin err++; $display("FAIL bp_drain got=%b want=0", full); end
  endtask

  task automatic test_same_cycle();
    int k = 0;
    send_group(2, 2, 2, 2);
    send_group(-3, -3, -3, -3);
    wait_full("sc_first");
    while (xst !== 2'd2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk++; if (full !== 1'b1 || xst !== 2'd2) begin err++; $display("FAIL sc_setup full=%b xst=%0d want 1/2", full, xst); end
    pop = ~pop;
    @(posedge clk); #1;
    chk++; if (full !== 1'b0) begin err++; $display("FAIL sc_fall got=%b want=0", full); end
    @(posedge clk); #1;
    chk++; if (full !== 1'b1) begin err++; $display("FAIL sc_rise got=%b want=1", full); end
    chk++; if ($signed(rdata) !== -6'sd12) begin err++; $display("FAIL sc_sum got=%0d want=-12", $signed(rdata)); end
    do_pop();
  endtask

  task automatic test_flush(input bit use_setn);
    int base = tog_cnt;
    logic pop_snap;
    send_word(5); send_word(5);
    wait_tog(base, 2, "flush_part");
    repeat (4) @(negedge clk);
    pop_snap = in_pop;
    if (use_setn) setn = 1'b0; else clear = 1'b1;
    @(negedge clk);
    setn = 1'b1; clear = 1'b0;
    chk++; if (in_pop !== pop_snap) begin err++; $display("FAIL flush_in_pop setn=%0d got=%b want=%b", use_setn, in_pop, pop_snap); end
    chk++; if (xst !== 2'd0) begin err++; $display("FAIL flush_xst setn=%0d got=%0d want=0", use_setn, xst); end
    send_group(1, 1, 1, 1);
    wait_full("flush");
    chk++; if ($signed(rdata) !== 6'sd4) begin err++; $display("FAIL flush_sum setn=%0d got=%0d want=4", use_setn, $signed(rdata)); end
    chk++; if (tog_cnt - base !== 6) begin err++; $display("FAIL flush_tog setn=%0d got=%0d want=6", use_setn, tog_cnt - base); end
    do_pop();
  endtask

  task automatic test_rstn();
    int base = tog_cnt;
    send_word(5); send_word(5); send_word(5);
    wait_tog(base, 3, "rstn_part");
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk++; if (in_pop !== 1'b0) begin err++; $display("FAIL rstn_in_pop got=%b want=0", in_pop); end
    chk++; if (full !== 1'b0)   begin err++; $display("FAIL rstn_full got=%b want=0", full); end
    chk++; if (rdata !== 6'd0)  begin err++; $display("FAIL rstn_rdata got=%0d want=0", rdata); end
    chk++; if (xst !== 2'd0)    begin err++; $display("FAIL rstn_xst got=%0d want=0", xst); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    send_group(2, 2, 2, 2);
    wait_full("rstn");
    chk++; if ($signed(rdata) !== 6'sd8) begin err++; $display("FAIL rstn_sum got=%0d want=8", $signed(rdata)); end
    do_pop();
  endtask

  initial begin
    chk = 0; err = 0; tog_cnt = 0; drop_t = 0;
    pop_seen = 1'b0; full_prev = 1'b0;
    rstn = 1'b0; setn = 1'b1; clear = 1'b0; pop = 1'b0;
    in_full = 1'b0; in_rdata = '0;
    fork
      // Upstream: present a word, drop in_full two cycles after each in_pop toggle.
      forever begin
        @(negedge clk);
        if (!rstn) begin
          in_full = 1'b0;
          drop_t = 0;
          pop_seen = in_pop;
        end else begin
          if (in_pop !== pop_seen) tog_cnt++;
          if (in_full && drop_t == 1) begin
            in_full = 1'b0;
            drop_t = 0;
          end else if (in_full && in_pop !== pop_seen) begin
            drop_t = 1;
          end else if (!in_full && up_q.size() > 0) begin
            in_rdata = up_q.pop_front();
            in_full = 1'b1;
          end
          pop_seen = in_pop;
        end
      end
      // Scoreboard: every rising full must carry the next expected sum.
      forever begin
        @(negedge clk);
        if (full === 1'b1 && full_prev !== 1'b1) begin
          chk++;
          if (exp_q.size() == 0) begin
            err++;
            $display("FAIL sb_unexpected got=%0d want=none", $signed(rdata));
          end else begin
            exp_v = exp_q.pop_front();
            if ($signed(rdata) !== exp_v) begin
              err++;
              $display("FAIL sb_sum got=%0d want=%0d", $signed(rdata), exp_v);
            end
          end
        end
        full_prev = full;
      end
    join_none

    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_same_cycle();
    test_flush(1'b0);
    test_flush(1'b1);
    test_rstn();
    repeat (5) @(negedge clk);
    chk++;
    if (exp_q.size() != 0) begin
      err++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/sdm_dec.md
# sdm_dec

Decimating accumulator placed directly downstream of `sdm_rx`. It pulls signed sample words from the receiver through the receiver's `full`/toggle-`pop` handshake and sums each group of 2^RATE consecutive samples without loss. Each completed sum is presented to the next consumer through the same `full`/toggle-`pop` handshake. This reduces the receiver's word rate by 2^RATE and adds RATE bits of resolution.

## Interface
- `DMSB`, default 3: MSB index of the input sample (signed, DMSB+1 bits).
- `RATE`, default 2: log2 of the decimation ratio. The block sums N = 2^RATE samples per output.
- `OMSB`, default DMSB+RATE: MSB index of the output sum (signed). Fixed by formula, not overridable.

- `clk`  in  1  clock. All logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `setn`  in  1  synchronous active-low hold. While low, the block behaves as `clear`.
- `in_full`  in  1  upstream word available (`sdm_rx.full`).
- `in_rdata`  in  DMSB+1  signed upstream word (`sdm_rx.rdata`).
- `in_pop`  out  1  toggle to upstream (`sdm_rx.pop`). Each transition consumes one word.
- `full`  out  1  output sum valid.
- `pop`  in  1  toggle from the downstream consumer. Each transition releases `rdata`.
- `clear`  in  1  synchronous, level, active-high flush.
- `rdata`  out  OMSB+1  signed sum of the last N accepted samples.
- `xst`  out  2  current state code: IDLE=0, WAIT=1, EMIT=2.

## Operation
- Registers:
  - `acc`: signed, OMSB+1 bits.
  - `cnt`: RATE bits.
  - `pop_d`: registered copy of `pop`.
  - `state`.
- `in_rdata` is sign-extended to OMSB+1 bits before it is added. The sum of N samples of DMSB+1 bits always fits in OMSB+1 bits, so the adder never wraps or saturates.
- IDLE: when `in_full`=1, set `acc` <= `acc` + sext(`in_rdata`), toggle `in_pop`, go to WAIT. Otherwise stay in IDLE.
- WAIT: wait for `in_full`=0, which is the upstream acknowledge.
  - If `cnt` = N-1: set `cnt` <= 0 and go to EMIT.
  - Otherwise: set `cnt` <= `cnt`+1 and go to IDLE.
  - A word is never captured twice.
- EMIT, when the registered `full` is 0: set `rdata` <= `acc`, `full` <= 1, `acc` <= 0, and go to IDLE.
- EMIT, when `full` is 1: stall in EMIT. No upstream words are taken and `in_pop` is held. This is the backpressure path.
- Output release: a pop edge is `pop` != `pop_d`, with `pop_d` <= `pop` every cycle. A pop edge clears `full` to 0. `rdata` holds its value.
  - A pop edge while `full`=0 is ignored.
- `clear`=1 or `setn`=0 at a rising edge:
  - `acc`=0, `cnt`=0, `full`=0, state=IDLE.
  - `rdata` and `in_pop` keep their values, so no spurious upstream pop occurs.
  - `clear` and `setn` take priority over every other event in the same cycle.
- Reset values: `in_pop`=0, `full`=0, `rdata`=0, `xst`=0 (IDLE), `acc`=0, `cnt`=0, `pop_d`=0.

## Timing
- `in_full` and `pop` are synchronous to `clk`. The block applies no synchronizers.
- `in_pop` toggles on the first rising edge at which IDLE sees `in_full`=1. The sample is captured at that same edge.
- Minimum 3 cycles per input word: IDLE, WAIT, then the exit from WAIT once `in_full` has dropped.
- EMIT adds 1 cycle per group. `full` rises 1 cycle after the WAIT exit for the N-th sample.
- Same-cycle pop edge and EMIT: EMIT sees `full`=1 and stalls. `full` falls at that edge, and EMIT emits at the next edge. `full` goes 1→0→1, and no sum is lost.
- Pop edge and `clear` in the same cycle: `clear` wins and the result is `full`=0.
- Asynchronous `rstn` mid-group discards the partial sum. After release, the first output is the sum of the first N words accepted after reset.
- A partial group is never emitted.

## Test plan
The bench's upstream model raises `in_full` with a word and drops it 2 cycles after each `in_pop` toggle. All scenarios use DMSB=3, RATE=2 unless stated otherwise.
- Words 1,2,3,4 → `full`=1, `rdata`=10, exactly 4 `in_pop` toggles. A consumer pop toggle → `full`=0 on the next edge.
- Words -8,-8,-8,-8 → `rdata`=-32 (6'b100000). Words 7,7,7,7 → `rdata`=28. Confirms the range limits with no wrap.
- Consumer never pops, upstream always full → exactly 8 `in_pop` toggles, then `in_pop` stays constant, `xst`=2, and the first `rdata` is held. One pop toggle → second sum appears 2 cycles later.
- Pop toggle timed so it lands in the same cycle the 8th word's EMIT is evaluated → `full` goes 1,0,1 on consecutive edges, and the second sum is correct.
- Mid-group: words 5,5 then `clear`=1 for 1 cycle, then words 1,1,1,1 → `rdata`=4, `in_pop` toggle count is 6. Repeat using `setn`=0 instead of `clear` with the same result.
- `rstn` asserted after 3 words → all outputs 0 immediately. After release, words 2,2,2,2 → `rdata`=8.
